// File: rtl/jpeg_pkg.sv
// Shared JPEG block constants: zigzag scan table, block geometry, coefficient pair type.
package jpeg_pkg;

    localparam int COEF_W    = 16;
    localparam int BLK_BEATS = 32;

    typedef logic signed [1:0][COEF_W-1:0] coef_pair_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_t;

    // Entry p is the raster index of zigzag position p.
    localparam logic [5:0] ZZ_LUT [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz_addr(input logic [4:0] beat, input logic lane);
        return ZZ_LUT[{beat, lane}];
    endfunction

endpackage

// File: rtl/zz_block_buf.sv
// Two 64-entry coefficient banks: paired writes at adjacent indices, two independent reads.
// Reads are combinational; writes land on posedge when we is set.
module zz_block_buf
    import jpeg_pkg::*;
#(
    parameter int DATA_W = COEF_W
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic                   wr_bank,
    input  logic [4:0]             wr_beat,
    input  logic [1:0][DATA_W-1:0] wr_data,
    input  logic                   rd_bank,
    input  logic [5:0]             rd_idx0,
    input  logic [5:0]             rd_idx1,
    output logic [1:0][DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:1][0:63];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][{wr_beat, 1'b0}] <= wr_data[0];
            mem[wr_bank][{wr_beat, 1'b1}] <= wr_data[1];
        end
    end

    always_comb begin
        rd_data    = '0;
        rd_data[0] = mem[rd_bank][rd_idx0];
        rd_data[1] = mem[rd_bank][rd_idx1];
    end

endmodule

// File: rtl/zigzag_reorder.sv
// Raster-to-zigzag reorder of 8x8 coefficient blocks through a ping-pong buffer.
// Latency: output beat 0 one cycle after the in_eob beat; no backpressure, en freezes everything.
module zigzag_reorder
    import jpeg_pkg::*;
#(
    parameter int DATA_W = COEF_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [1:0][DATA_W-1:0] in_data,
    input  logic                   in_eob,
    input  logic                   in_sob,
    input  logic                   in_sof,
    output logic                   out_valid,
    output logic [1:0][DATA_W-1:0] out_data,
    output logic                   out_eob,
    output logic                   out_sob,
    output logic                   out_sof,
    output logic                   out_err
);

    localparam logic [4:0] LAST_BEAT = 5'(BLK_BEATS - 1);

    logic [4:0]  wr_cnt;
    logic        wr_bank;
    logic        wr_started;
    logic        wr_sof;
    logic [1:0]  full;
    logic [1:0]  blk_sof;

    rd_state_t   rd_state;
    logic [4:0]  rd_cnt;
    logic        rd_bank;

    logic [4:0]  wr_idx;
    logic        beat_ok;
    logic        wr_blocked;
    logic        blk_done;
    logic        err_now;
    logic [1:0]  free_mask;
    logic [1:0]  set_mask;
    logic [1:0]  full_seen;
    logic        rd_last;
    logic        emit;
    logic [4:0]  rd_beat;
    logic [1:0][DATA_W-1:0] rd_data;

    assign wr_idx     = in_sob ? 5'd0 : wr_cnt;
    assign beat_ok    = en & in_valid & (in_sob | wr_started);

    // A bank freed by the reader this cycle is already writable for a completing block.
    assign rd_last    = en & (rd_state == RD_RUN) & (rd_cnt == LAST_BEAT);
    assign free_mask  = rd_last ? (2'b01 << rd_bank) : 2'b00;
    assign full_seen  = full & ~free_mask;
    assign wr_blocked = full_seen[wr_bank];

    assign blk_done   = beat_ok & in_eob & (wr_idx == LAST_BEAT);
    assign set_mask   = (blk_done & ~wr_blocked) ? (2'b01 << wr_bank) : 2'b00;
    assign err_now    = beat_ok & ((in_sob & (wr_cnt != 5'd0)) |
                                   (in_eob ? ((wr_idx != LAST_BEAT) | wr_blocked)
                                           : (wr_idx == LAST_BEAT)));

    assign emit       = en & ((rd_state == RD_RUN) | full[rd_bank]);
    assign rd_beat    = (rd_state == RD_RUN) ? rd_cnt : 5'd0;

    zz_block_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .we      (beat_ok & ~wr_blocked),
        .wr_bank (wr_bank),
        .wr_beat (wr_idx),
        .wr_data (in_data),
        .rd_bank (rd_bank),
        .rd_idx0 (zz_addr(rd_beat, 1'b0)),
        .rd_idx1 (zz_addr(rd_beat, 1'b1)),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt     <= '0;
            wr_bank    <= 1'b0;
            wr_started <= 1'b0;
            wr_sof     <= 1'b0;
            full       <= '0;
            blk_sof    <= '0;
        end else if (en) begin
            full <= full_seen | set_mask;
            if (beat_ok) begin
                wr_started <= 1'b1;
                if (in_sob) begin
                    wr_sof <= in_sof;
                end
                if (in_eob) begin
                    wr_cnt <= '0;
                end else begin
                    wr_cnt <= wr_idx + 5'd1;
                end
                if (blk_done && !wr_blocked) begin
                    wr_bank          <= ~wr_bank;
                    blk_sof[wr_bank] <= wr_sof;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= RD_IDLE;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_sof   <= 1'b0;
            out_err   <= 1'b0;
        end else if (en) begin
            out_err   <= err_now;
            out_valid <= emit;
            out_sob   <= emit & (rd_beat == 5'd0);
            out_eob   <= emit & (rd_beat == LAST_BEAT);
            out_sof   <= emit & (rd_beat == 5'd0) & blk_sof[rd_bank];
            if (emit) begin
                out_data <= rd_data;
            end
            case (rd_state)
                RD_IDLE: begin
                    // Beat 0 goes out on the same edge the FSM leaves IDLE.
                    if (full[rd_bank]) begin
                        rd_state <= RD_RUN;
                        rd_cnt   <= 5'd1;
                    end
                end
                RD_RUN: begin
                    if (rd_cnt == LAST_BEAT) begin
                        rd_bank <= ~rd_bank;
                        rd_cnt  <= '0;
                        if (!full[~rd_bank]) begin
                            rd_state <= RD_IDLE;
                        end
                    end else begin
                        rd_cnt <= rd_cnt + 5'd1;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zigzag_reorder.sv
// Randomized bench for zigzag_reorder against a diagonal-walk zigzag model.
module tb_zigzag_reorder;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b1;
    logic              in_valid = 1'b0;
    logic [1:0][15:0]  in_data = '0;
    logic              in_eob = 1'b0;
    logic              in_sob = 1'b0;
    logic              in_sof = 1'b0;
    logic              out_valid;
    logic [1:0][15:0]  out_data;
    logic              out_eob;
    logic              out_sob;
    logic              out_sof;
    logic              out_err;

    zigzag_reorder #(.DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid), .in_data(in_data), .in_eob(in_eob), .in_sob(in_sob), .in_sof(in_sof),
        .out_valid(out_valid), .out_data(out_data), .out_eob(out_eob), .out_sob(out_sob),
        .out_sof(out_sof), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: zigzag order derived by walking anti-diagonals.
    int          zz [64];
    logic [15:0] mcoef [64];
    int          m_n = 0;
    bit          m_started = 0;
    bit          m_sof = 0;
    int          exp_errs = 0;
    logic [34:0] exp_q [$];
    logic [34:0] cap [$];

    function automatic void build_zz();
        int p = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[p] = r * 8 + (s - r); p++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[p] = r * 8 + (s - r); p++; end
            end
        end
    endfunction

    function automatic void push_block();
        for (int j = 0; j < 32; j++)
            exp_q.push_back({mcoef[zz[2*j+1]], mcoef[zz[2*j]], 1'(j == 0), 1'(j == 31), 1'(j == 0 && m_sof)});
    endfunction

    function automatic void model_beat(input bit sob, input bit eob, input bit sof,
                                       input logic [15:0] d0, input logic [15:0] d1);
        if (!m_started && !sob) return;
        if (sob) begin
            if (m_n != 0) exp_errs++;
            m_n = 0; m_sof = sof; m_started = 1;
        end
        mcoef[2*m_n] = d0; mcoef[2*m_n+1] = d1; m_n++;
        if (eob) begin
            if (m_n == 32) push_block(); else exp_errs++;
            m_n = 0;
        end else if (m_n == 32) begin
            exp_errs++; m_n = 0;
        end
    endfunction

    // Monitor: counts only edges where en was high and reset was released.
    int cyc = 0;
    int run_first = -1;
    int run_last = -1;
    int n_sof = 0;
    int n_err_pulse = 0;
    bit en_at;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            en_at = en;
            #1;
            if (en_at && rst_n) begin
                if (out_valid) begin
                    logic [34:0] obs;
                    obs = {out_data[1], out_data[0], out_sob, out_eob, out_sof};
                    cap.push_back(obs);
                    if (run_first < 0) run_first = cyc;
                    run_last = cyc;
                    if (out_sof) n_sof++;
                    if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                    else chk("beat", obs, exp_q.pop_front());
                end
                if (out_err) n_err_pulse++;
            end
        end
    end

    bit          en_rand = 0;
    int          eob_edge = 0;
    logic [15:0] blk [64];
    logic [15:0] seq [4][64];

    task automatic put_beat(input bit sob, input bit eob, input bit sof,
                            input logic [15:0] d0, input logic [15:0] d1);
        bit acc = 0;
        while (!acc) begin
            @(negedge clk);
            en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = 1'b1; in_sob = sob; in_eob = eob; in_sof = sof;
            in_data[0] = d0; in_data[1] = d1;
            if (en) begin
                acc = 1;
                model_beat(sob, eob, sof, d0, d1);
                if (eob) eob_edge = cyc + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = 1'b0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
        end
    endtask

    task automatic send_blk(input bit sof, input int maxgap);
        for (int k = 0; k < 32; k++) begin
            put_beat(k == 0, k == 31, sof && k == 0, blk[2*k], blk[2*k+1]);
            if (maxgap > 0 && k < 31 && $urandom_range(0, 3) == 0) idle($urandom_range(0, maxgap));
        end
    endtask

    task automatic send_partial(input int n, input bit eob_last);
        for (int k = 0; k < n; k++)
            put_beat(k == 0, eob_last && k == n - 1, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    task automatic drain(input int budget);
        int b = budget;
        en_rand = 0;
        while (exp_q.size() != 0 && b > 0) begin idle(1); b--; end
        if (b == 0) chk("drain_timeout", exp_q.size(), 0);
        idle(4);
    endtask

    task automatic run_seq();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 64; i++) blk[i] = seq[b][i];
            send_blk(b == 0, 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [34:0] ref_cap [$];
        int e0;
        int c0;
        int b;
        build_zz();

        #23;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_markers", {out_sob, out_eob, out_sof}, 0);
        chk("rst_err", out_err, 0);
        @(negedge clk); rst_n = 1'b1;
        idle(3);

        // Ramp block
        for (int i = 0; i < 64; i++) blk[i] = 16'(i);
        cap.delete(); run_first = -1;
        send_blk(1'b1, 0);
        drain(100);
        chk("ramp_count", cap.size(), 32);
        if (cap.size() == 32) begin
            chk("ramp_b0", cap[0], {16'd1, 16'd0, 1'b1, 1'b0, 1'b1});
            chk("ramp_b1", cap[1], {16'd16, 16'd8, 1'b0, 1'b0, 1'b0});
            chk("ramp_b2", cap[2], {16'd2, 16'd9, 1'b0, 1'b0, 1'b0});
            chk("ramp_b31", cap[31], {16'd63, 16'd62, 1'b0, 1'b1, 1'b0});
        end
        chk("ramp_latency", run_first, eob_edge + 1);

        // Back-to-back full rate, then the same traffic with en toggling
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 64; i++) seq[k][i] = 16'($urandom);
        cap.delete(); run_first = -1; c0 = n_sof;
        run_seq();
        drain(200);
        chk("b2b_count", cap.size(), 128);
        chk("b2b_span", run_last - run_first, 127);
        chk("b2b_sof", n_sof - c0, 1);
        ref_cap = cap;

        cap.delete(); en_rand = 1;
        run_seq();
        drain(400);
        chk("en_count", cap.size(), ref_cap.size());
        for (int i = 0; i < cap.size() && i < ref_cap.size(); i++) chk("en_seq", cap[i], ref_cap[i]);

        // Random gaps
        e0 = n_err_pulse; cap.delete();
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < 64; i++) blk[i] = 16'($urandom);
            send_blk($urandom_range(0, 7) == 0, 20);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 20));
        end
        drain(200);
        chk("gap_count", cap.size(), 6400);
        chk("gap_err", n_err_pulse - e0, 0);

        // Malformed: restart at beat 10, then a clean block
        e0 = n_err_pulse; cap.delete();
        send_partial(10, 1'b0);
        for (int i = 0; i < 64; i++) blk[i] = 16'($urandom);
        send_blk(1'b0, 0);
        drain(100);
        chk("sob10_err", n_err_pulse - e0, 1);
        chk("sob10_count", cap.size(), 32);

        // Malformed: early eob on beat 20
        e0 = n_err_pulse; cap.delete();
        send_partial(21, 1'b1);
        drain(50);
        chk("eob20_err", n_err_pulse - e0, 1);
        chk("eob20_count", cap.size(), 0);
        chk("err_total", n_err_pulse, exp_errs);

        // Reset during readout at beat 15
        for (int i = 0; i < 64; i++) blk[i] = 16'($urandom);
        cap.delete();
        send_blk(1'b1, 0);
        b = 200;
        while (cap.size() < 16 && b > 0) begin idle(1); b--; end
        if (b == 0) chk("rst_wait_timeout", cap.size(), 16);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_sob = 1'b0; in_eob = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        exp_q.delete(); m_started = 0; m_n = 0;
        idle(3);
        @(negedge clk); rst_n = 1'b1;
        cap.delete();
        for (int k = 0; k < 5; k++) put_beat(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
        idle(40);
        chk("postrst_quiet", cap.size(), 0);
        send_blk(1'b1, 0);
        drain(100);
        chk("postrst_count", cap.size(), 32);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
